// File: rtl/pool1d_stream.sv
// ============================================================================
// Module: pool1d_stream
//
// Streaming 1-D pooling stage that sits directly behind a convolution layer.
// It accepts the conv output stream one sample at a time over a valid/ready
// handshake. For every window of POOL consecutive inputs, advancing STRIDE
// inputs per window, it emits one pooled sample.
//
// Build option:
//   POOL_AVG_EN  undefined -> max pooling (default)
//                defined   -> average pooling: (sum of window) >>> log2(POOL).
//                             POOL must be a power of two in this mode.
//
// Parameters:
//   T        data width, signed two's complement
//   X_COUNT  input samples per frame
//   POOL     window length (1..X_COUNT)
//   STRIDE   window advance (1..POOL)
//   Y_COUNT  output samples per frame (derived, leave at default)
//
// Ports:
//   clk           clock, rising edge
//   reset         synchronous, active-high
//   s_data_in_y   input sample
//   s_valid_y     input valid
//   s_ready_y     input ready (combinational from m_valid_z / m_ready_z)
//   m_data_out_z  pooled output sample (registered)
//   m_valid_z     output valid (registered)
//   m_ready_z     output ready
//   frame_done    pulses with the transfer of the last output of a frame
// ============================================================================
module pool1d_stream #(
    parameter int T       = 16,
    parameter int X_COUNT = 121,
    parameter int POOL    = 2,
    parameter int STRIDE  = 2,
    parameter int Y_COUNT = (X_COUNT - POOL) / STRIDE + 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [T-1:0] s_data_in_y,
    input  logic         s_valid_y,
    output logic         s_ready_y,
    output logic [T-1:0] m_data_out_z,
    output logic         m_valid_z,
    input  logic         m_ready_z,
    output logic         frame_done
);

    localparam int CNT_W = (X_COUNT > 1) ? $clog2(X_COUNT) : 1;
    localparam int PH_W  = (STRIDE > 1) ? $clog2(STRIDE) : 1;
    localparam int OC_W  = (Y_COUNT > 1) ? $clog2(Y_COUNT) : 1;

    // The incoming sample always completes the window, so only the previous
    // POOL-1 samples need storing.
    localparam int HIST  = (POOL > 1) ? POOL - 1 : 1;

    localparam logic [CNT_W-1:0] LAST_IN = CNT_W'(X_COUNT - 1);
    localparam logic [CNT_W-1:0] FULL_AT = CNT_W'(POOL - 1);
    localparam logic [PH_W-1:0]  PH_LAST = PH_W'(STRIDE - 1);
    localparam logic [OC_W-1:0]  OC_LAST = OC_W'(Y_COUNT - 1);

    logic signed [T-1:0] win [HIST];
    logic signed [T-1:0] new_s;
    logic signed [T-1:0] pool_result;
    logic [CNT_W-1:0]    in_cnt;
    logic [PH_W-1:0]     phase;
    logic [OC_W-1:0]     out_cnt;
    logic                accept;
    logic                window_full;
    logic                complete;
    logic                out_xfer;

    assign new_s = s_data_in_y;

    // A held output blocks the input. Letting m_ready_z through combinationally
    // allows a full-rate stream, because the output register can be refilled
    // in the same cycle that it is drained.
    assign s_ready_y   = !m_valid_z || m_ready_z;
    assign accept      = s_valid_y && s_ready_y;
    assign out_xfer    = m_valid_z && m_ready_z;

    // The window is full once this accept brings the frame count to POOL.
    // Phase then selects every STRIDE-th position after that point.
    assign window_full = (in_cnt >= FULL_AT);
    assign complete    = accept && window_full && (phase == '0);

    assign frame_done  = out_xfer && (out_cnt == OC_LAST);

`ifdef POOL_AVG_EN
    localparam int LOG2P = $clog2(POOL);
    localparam int SUM_W = T + LOG2P;

    logic signed [SUM_W-1:0] sum_acc;
    logic signed [SUM_W-1:0] sum_shr;

    // Average mode. The sum is widened by log2(POOL) bits so it cannot overflow.
    // The arithmetic shift rounds toward minus infinity, and the quotient
    // always fits back into T bits.
    always_comb begin
        sum_acc = SUM_W'(new_s);
        for (int i = 0; i < POOL - 1; i++) begin
            sum_acc = sum_acc + SUM_W'(win[i]);
        end
        sum_shr     = sum_acc >>> LOG2P;
        pool_result = T'(sum_shr);
    end
`else
    // Max mode: signed maximum of the incoming sample and the stored history.
    // When values tie, either one is a correct result.
    always_comb begin
        pool_result = new_s;
        for (int i = 0; i < POOL - 1; i++) begin
            if (win[i] > pool_result) begin
                pool_result = win[i];
            end
        end
    end
`endif

    // History shift register. The newest accepted sample goes into win[0].
    // At a frame boundary the stale contents are not cleared: in_cnt restarts
    // at zero, so no window can complete until the buffer has refilled with
    // samples from the new frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < HIST; i++) begin
                win[i] <= '0;
            end
        end else if (accept) begin
            win[0] <= new_s;
            for (int i = 1; i < HIST; i++) begin
                win[i] <= win[i-1];
            end
        end
    end

    // Frame position and stride alignment. Phase stays at zero until the first
    // full window, then cycles 0..STRIDE-1. The last sample of a frame returns
    // both counters to zero, so any trailing partial window is dropped and the
    // next frame can start on the following cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_cnt <= '0;
            phase  <= '0;
        end else if (accept) begin
            if (in_cnt == LAST_IN) begin
                in_cnt <= '0;
                phase  <= '0;
            end else begin
                in_cnt <= in_cnt + 1'b1;
                if (window_full) begin
                    phase <= (phase == PH_LAST) ? '0 : phase + 1'b1;
                end
            end
        end
    end

    // Output register with one cycle of latency. A completing accept reloads
    // the register even while the current value is draining, so valid stays
    // high. Accepts that do not complete a window leave the register
    // untouched, so a held value stays stable.
    always_ff @(posedge clk) begin
        if (reset) begin
            m_data_out_z <= '0;
            m_valid_z    <= 1'b0;
        end else if (complete) begin
            m_data_out_z <= pool_result;
            m_valid_z    <= 1'b1;
        end else if (out_xfer) begin
            m_valid_z    <= 1'b0;
        end
    end

    // Counts transferred outputs within the frame so that frame_done can mark
    // the last one. It wraps on its own at Y_COUNT.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_cnt <= '0;
        end else if (out_xfer) begin
            out_cnt <= (out_cnt == OC_LAST) ? '0 : out_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pool1d_stream.sv
// ============================================================================
// Testbench: tb_pool1d_stream
//
// Drives two instances of pool1d_stream:
//   A  default configuration (121 inputs, POOL=2, STRIDE=2)
//   B  short 5-sample frame with a sliding window (POOL=3, STRIDE=1;
//      POOL=4 when POOL_AVG_EN is defined)
// Expected outputs come from a window-by-window reference model that works
// on whole frames with plain integer arithmetic.
// ============================================================================
`timescale 1ns/1ps
module tb_pool1d_stream;

    localparam int T  = 16;
    localparam int XA = 121;
    localparam int PA = 2;
    localparam int SA = 2;
    localparam int XB = 5;
    localparam int SB = 1;
`ifdef POOL_AVG_EN
    localparam int PB      = 4;
    localparam int EXP_ALT = -7;
`else
    localparam int PB      = 3;
    localparam int EXP_ALT = -5;
`endif
    localparam int BUDGET = 40;

    logic         clk = 1'b0;
    logic         reset;

    logic [T-1:0] s_data_in_y;
    logic         s_valid_y;
    logic         s_ready_y;
    logic [T-1:0] m_data_out_z;
    logic         m_valid_z;
    logic         m_ready_z;
    logic         frame_done;

    logic [T-1:0] s_data_b;
    logic         s_valid_b;
    logic         s_ready_b;
    logic [T-1:0] m_data_b;
    logic         m_valid_b;
    logic         m_ready_b;
    logic         frame_done_b;

    int checks = 0;
    int errors = 0;

    int got_a[$];
    int fd_a[$];
    int got_b[$];
    int fd_b[$];

    // Free-running clock with a 10 ns period.
    always #5 clk = ~clk;

    pool1d_stream #(.T(T), .X_COUNT(XA), .POOL(PA), .STRIDE(SA)) dut_a (
        .clk          (clk),
        .reset        (reset),
        .s_data_in_y  (s_data_in_y),
        .s_valid_y    (s_valid_y),
        .s_ready_y    (s_ready_y),
        .m_data_out_z (m_data_out_z),
        .m_valid_z    (m_valid_z),
        .m_ready_z    (m_ready_z),
        .frame_done   (frame_done)
    );

    pool1d_stream #(.T(T), .X_COUNT(XB), .POOL(PB), .STRIDE(SB)) dut_b (
        .clk          (clk),
        .reset        (reset),
        .s_data_in_y  (s_data_b),
        .s_valid_y    (s_valid_b),
        .s_ready_y    (s_ready_b),
        .m_data_out_z (m_data_b),
        .m_valid_z    (m_valid_b),
        .m_ready_z    (m_ready_b),
        .frame_done   (frame_done_b)
    );

    // Output monitors. They sample mid-cycle, record every output transfer,
    // and record the output index at which each frame_done pulse appears.
    always @(negedge clk) begin
        if (!reset) begin
            if (m_valid_z && m_ready_z) got_a.push_back(int'($signed(m_data_out_z)));
            if (frame_done) fd_a.push_back(got_a.size() - 1);
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (m_valid_b && m_ready_b) got_b.push_back(int'($signed(m_data_b)));
            if (frame_done_b) fd_b.push_back(got_b.size() - 1);
        end
    end

    // Reference model: window j covers inputs j*stride .. j*stride+pool-1.
    // Any trailing samples that do not fill a window produce no output.
    function automatic void model_frame(input int pool, input int stride,
                                        input int xs[$], output int ys[$]);
        int n;
        ys = {};
        n = (xs.size() - pool) / stride + 1;
        for (int j = 0; j < n; j++) begin
            int acc;
`ifdef POOL_AVG_EN
            acc = 0;
            for (int k = 0; k < pool; k++) acc += xs[j*stride + k];
            if (acc < 0 && (acc % pool) != 0) acc = acc / pool - 1;
            else acc = acc / pool;
`else
            acc = xs[j*stride];
            for (int k = 1; k < pool; k++)
                if (xs[j*stride + k] > acc) acc = xs[j*stride + k];
`endif
            ys.push_back(acc);
        end
    endfunction

    // Offers one sample to DUT A and waits (bounded) for its acceptance.
    // Called and returns at 1 ns after a rising edge.
    task automatic applyStimulus(input int val);
        int waited;
        waited = 0;
        s_data_in_y = T'(val);
        s_valid_y   = 1'b1;
        forever begin
            @(negedge clk);
            if (s_ready_y) break;
            waited++;
            if (waited > BUDGET) begin
                checks++;
                errors++;
                $display("[TB] FAIL accept_timeout_a: s_ready_y got 0 expected 1 within %0d cycles", BUDGET);
                break;
            end
        end
        @(posedge clk);
        #1;
        s_valid_y = 1'b0;
    endtask

    task automatic applyStimulusB(input int val);
        int waited;
        waited = 0;
        s_data_b  = T'(val);
        s_valid_b = 1'b1;
        forever begin
            @(negedge clk);
            if (s_ready_b) break;
            waited++;
            if (waited > BUDGET) begin
                checks++;
                errors++;
                $display("[TB] FAIL accept_timeout_b: s_ready_y got 0 expected 1 within %0d cycles", BUDGET);
                break;
            end
        end
        @(posedge clk);
        #1;
        s_valid_b = 1'b0;
    endtask

    task automatic send_frame_a(input int xs[$], input int max_gap);
        foreach (xs[i]) begin
            if (max_gap > 0) begin
                repeat ($urandom_range(0, max_gap)) begin
                    @(posedge clk);
                    #1;
                end
            end
            applyStimulus(xs[i]);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        m_ready_z = 1'b0;
        m_ready_b = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (m_valid_z !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", m_valid_z); end
        checks++; if (m_data_out_z !== '0) begin errors++; $display("[TB] FAIL reset_data: got %0h expected 0", m_data_out_z); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_done: got %b expected 0", frame_done); end
        checks++; if (m_valid_b !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid_b: got %b expected 0", m_valid_b); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (s_ready_y !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 1", s_ready_y); end
        checks++; if (s_ready_b !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready_b: got %b expected 1", s_ready_b); end
        @(posedge clk);
        #1;
        m_ready_z = 1'b1;
        m_ready_b = 1'b1;
    endtask

    task automatic test_ramp();
        int xs[$];
        int ys[$];
        int base;
        int fbase;
        for (int i = 0; i < XA; i++) xs.push_back(i);
        model_frame(PA, SA, xs, ys);
        base  = got_a.size();
        fbase = fd_a.size();
        send_frame_a(xs, 0);
        idle(8);
        checks++;
        if (got_a.size() - base !== ys.size()) begin
            errors++; $display("[TB] FAIL ramp_count: got %0d expected %0d", got_a.size() - base, ys.size());
        end
        for (int i = 0; i < ys.size(); i++) begin
            checks++;
            if (base + i >= got_a.size()) begin
                errors++; $display("[TB] FAIL ramp_out[%0d]: got none expected %0d", i, ys[i]);
            end else if (got_a[base + i] !== ys[i]) begin
                errors++; $display("[TB] FAIL ramp_out[%0d]: got %0d expected %0d", i, got_a[base + i], ys[i]);
            end
        end
        checks++;
        if (fd_a.size() - fbase !== 1) begin
            errors++; $display("[TB] FAIL ramp_fd_count: got %0d expected 1", fd_a.size() - fbase);
        end else begin
            checks++;
            if (fd_a[fbase] !== base + ys.size() - 1) begin
                errors++; $display("[TB] FAIL ramp_fd_pos: got %0d expected %0d", fd_a[fbase] - base, ys.size() - 1);
            end
        end
    endtask

    task automatic test_alternating();
        int xs[$];
        int ys[$];
        int base;
        for (int i = 0; i < XA; i++) xs.push_back((i % 2 == 0) ? -5 : -9);
        model_frame(PA, SA, xs, ys);
        base = got_a.size();
        send_frame_a(xs, 0);
        idle(8);
        checks++;
        if (got_a.size() - base !== ys.size()) begin
            errors++; $display("[TB] FAIL alt_count: got %0d expected %0d", got_a.size() - base, ys.size());
        end
        checks++;
        if (got_a.size() <= base || got_a[base] !== EXP_ALT) begin
            errors++; $display("[TB] FAIL alt_first: got %0d expected %0d", (got_a.size() > base) ? got_a[base] : 0, EXP_ALT);
        end
        for (int i = 0; i < ys.size(); i++) begin
            checks++;
            if (base + i >= got_a.size() || got_a[base + i] !== ys[i]) begin
                errors++; $display("[TB] FAIL alt_out[%0d]: got %0d expected %0d", i, (base + i < got_a.size()) ? got_a[base + i] : 0, ys[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int xs[$];
        int ys[$];
        int base;
        int fbase;
        int w;
        for (int i = 0; i < XA; i++) xs.push_back(i);
        model_frame(PA, SA, xs, ys);
        base  = got_a.size();
        fbase = fd_a.size();
        m_ready_z = 1'b0;
        fork
            send_frame_a(xs, 0);
            begin
                w = 0;
                @(negedge clk);
                while (!m_valid_z && w < BUDGET) begin
                    @(negedge clk);
                    w++;
                end
                checks++;
                if (m_valid_z !== 1'b1) begin
                    errors++; $display("[TB] FAIL bp_first_valid: got %b expected 1", m_valid_z);
                end
                for (int c = 0; c < 10; c++) begin
                    checks++;
                    if (s_ready_y !== 1'b0) begin
                        errors++; $display("[TB] FAIL bp_ready[%0d]: got %b expected 0", c, s_ready_y);
                    end
                    checks++;
                    if (int'($signed(m_data_out_z)) !== ys[0] || m_valid_z !== 1'b1) begin
                        errors++; $display("[TB] FAIL bp_hold[%0d]: got %0d/%b expected %0d/1", c, $signed(m_data_out_z), m_valid_z, ys[0]);
                    end
                    @(negedge clk);
                end
                @(posedge clk);
                #1;
                m_ready_z = 1'b1;
            end
        join
        idle(8);
        checks++;
        if (got_a.size() - base !== ys.size()) begin
            errors++; $display("[TB] FAIL bp_count: got %0d expected %0d", got_a.size() - base, ys.size());
        end
        for (int i = 0; i < ys.size(); i++) begin
            checks++;
            if (base + i >= got_a.size() || got_a[base + i] !== ys[i]) begin
                errors++; $display("[TB] FAIL bp_out[%0d]: got %0d expected %0d", i, (base + i < got_a.size()) ? got_a[base + i] : 0, ys[i]);
            end
        end
        checks++;
        if (fd_a.size() - fbase !== 1) begin
            errors++; $display("[TB] FAIL bp_fd_count: got %0d expected 1", fd_a.size() - fbase);
        end
    endtask

    task automatic test_sliding_window();
        int xs1[$];
        int xs2[$];
        int ys1[$];
        int ys2[$];
        int exp[$];
        int base;
        int fbase;
        xs1 = '{4, 1, 7, 2, 0};
        for (int i = 0; i < XB; i++) xs2.push_back(int'($urandom_range(0, 40)) - 20);
        model_frame(PB, SB, xs1, ys1);
        model_frame(PB, SB, xs2, ys2);
        exp = {ys1, ys2};
        base  = got_b.size();
        fbase = fd_b.size();
        foreach (xs1[i]) applyStimulusB(xs1[i]);
        foreach (xs2[i]) applyStimulusB(xs2[i]);
        idle(5);
        checks++;
        if (got_b.size() - base !== exp.size()) begin
            errors++; $display("[TB] FAIL slide_count: got %0d expected %0d", got_b.size() - base, exp.size());
        end
        for (int i = 0; i < exp.size(); i++) begin
            checks++;
            if (base + i >= got_b.size() || got_b[base + i] !== exp[i]) begin
                errors++; $display("[TB] FAIL slide_out[%0d]: got %0d expected %0d", i, (base + i < got_b.size()) ? got_b[base + i] : 0, exp[i]);
            end
        end
        checks++;
        if (fd_b.size() - fbase !== 2) begin
            errors++; $display("[TB] FAIL slide_fd_count: got %0d expected 2", fd_b.size() - fbase);
        end else begin
            checks++;
            if (fd_b[fbase] !== base + ys1.size() - 1 || fd_b[fbase + 1] !== base + exp.size() - 1) begin
                errors++; $display("[TB] FAIL slide_fd_pos: got %0d,%0d expected %0d,%0d", fd_b[fbase] - base, fd_b[fbase + 1] - base, ys1.size() - 1, exp.size() - 1);
            end
        end
    endtask

    task automatic test_reset_midframe();
        int xs[$];
        int ys[$];
        int base;
        int fbase;
        for (int i = 0; i < XA; i++) xs.push_back(i);
        model_frame(PA, SA, xs, ys);
        for (int i = 0; i < 37; i++) applyStimulus(i);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (m_valid_z !== 1'b0) begin errors++; $display("[TB] FAIL midreset_valid: got %b expected 0", m_valid_z); end
        checks++; if (m_data_out_z !== '0) begin errors++; $display("[TB] FAIL midreset_data: got %0h expected 0", m_data_out_z); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (s_ready_y !== 1'b1) begin errors++; $display("[TB] FAIL midreset_ready: got %b expected 1", s_ready_y); end
        @(posedge clk);
        #1;
        base  = got_a.size();
        fbase = fd_a.size();
        send_frame_a(xs, 0);
        idle(8);
        checks++;
        if (got_a.size() - base !== ys.size()) begin
            errors++; $display("[TB] FAIL midreset_count: got %0d expected %0d", got_a.size() - base, ys.size());
        end
        for (int i = 0; i < ys.size(); i++) begin
            checks++;
            if (base + i >= got_a.size() || got_a[base + i] !== ys[i]) begin
                errors++; $display("[TB] FAIL midreset_out[%0d]: got %0d expected %0d", i, (base + i < got_a.size()) ? got_a[base + i] : 0, ys[i]);
            end
        end
        checks++;
        if (fd_a.size() - fbase !== 1) begin
            errors++; $display("[TB] FAIL midreset_fd_count: got %0d expected 1", fd_a.size() - fbase);
        end else begin
            checks++;
            if (fd_a[fbase] !== base + ys.size() - 1) begin
                errors++; $display("[TB] FAIL midreset_fd_pos: got %0d expected %0d", fd_a[fbase] - base, ys.size() - 1);
            end
        end
    endtask

    task automatic test_back_to_back();
        int xs1[$];
        int xs2[$];
        int ys1[$];
        int ys2[$];
        int exp[$];
        int base;
        int fbase;
        bit done;
        logic [T-1:0] r;
        for (int i = 0; i < XA; i++) begin r = T'($urandom); xs1.push_back(int'($signed(r))); end
        for (int i = 0; i < XA; i++) begin r = T'($urandom); xs2.push_back(int'($signed(r))); end
        model_frame(PA, SA, xs1, ys1);
        model_frame(PA, SA, xs2, ys2);
        exp = {ys1, ys2};
        base  = got_a.size();
        fbase = fd_a.size();
        done  = 1'b0;
        fork
            begin
                send_frame_a(xs1, 2);
                send_frame_a(xs2, 2);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    if (!done) m_ready_z = ($urandom_range(0, 3) != 0);
                end
            end
        join
        m_ready_z = 1'b1;
        idle(10);
        checks++;
        if (got_a.size() - base !== exp.size()) begin
            errors++; $display("[TB] FAIL b2b_count: got %0d expected %0d", got_a.size() - base, exp.size());
        end
        for (int i = 0; i < exp.size(); i++) begin
            checks++;
            if (base + i >= got_a.size() || got_a[base + i] !== exp[i]) begin
                errors++; $display("[TB] FAIL b2b_out[%0d]: got %0d expected %0d", i, (base + i < got_a.size()) ? got_a[base + i] : 0, exp[i]);
            end
        end
        checks++;
        if (fd_a.size() - fbase !== 2) begin
            errors++; $display("[TB] FAIL b2b_fd_count: got %0d expected 2", fd_a.size() - fbase);
        end else begin
            checks++;
            if (fd_a[fbase] !== base + ys1.size() - 1 || fd_a[fbase + 1] !== base + exp.size() - 1) begin
                errors++; $display("[TB] FAIL b2b_fd_pos: got %0d,%0d expected %0d,%0d", fd_a[fbase] - base, fd_a[fbase + 1] - base, ys1.size() - 1, exp.size() - 1);
            end
        end
    endtask

    // Safety net in case something stalls outside the bounded waits.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence.
    initial begin
        reset       = 1'b1;
        s_data_in_y = '0;
        s_valid_y   = 1'b0;
        m_ready_z   = 1'b0;
        s_data_b    = '0;
        s_valid_b   = 1'b0;
        m_ready_b   = 1'b0;
        test_reset();
        test_ramp();
        test_alternating();
        test_backpressure();
        test_sliding_window();
        test_reset_midframe();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
